// File: rtl/bec_pkg.sv
// Shared types and constants for the BEC point-multiply sequencer.
package bec_pkg;

    localparam int DEF_WORD_W = 32;
    localparam int DEF_KEY_W  = 163;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_BUSY,
        S_UNLOAD,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] ST_IDLE    = 16'hAB00;
    localparam logic [15:0] ST_STARTED = 16'hAB40;
    localparam logic [15:0] ST_RUN     = 16'hAB41;
    localparam logic [15:0] ST_PASS    = 16'hAB51;
    localparam logic [15:0] ST_ERR     = 16'hABEE;

    function automatic int n_words(input int key_w, input int word_w);
        return (key_w + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/bec_word_packer.sv
// Word <-> operand mapping: bit select of word wd inside a KEY_W operand,
// used to merge incoming words and to extract outgoing ones.
module bec_word_packer #(
    parameter int WORD_W  = 32,
    parameter int KEY_W   = 163,
    parameter int N_WORDS = 6,
    parameter int WD_W    = 3
) (
    input  logic [WD_W-1:0]   wd,
    input  logic [WORD_W-1:0] data_in,
    input  logic [KEY_W-1:0]  op_in,
    output logic [KEY_W-1:0]  sel,
    output logic [KEY_W-1:0]  spread,
    output logic [WORD_W-1:0] word_out,
    output logic              last
);

    // Bits past KEY_W in the final word simply have no home, so they drop
    // on load and read back as zero on unload.
    always_comb begin : map
        logic s;
        sel      = '0;
        spread   = '0;
        word_out = '0;
        for (int b = 0; b < KEY_W; b++) begin
            s         = (WD_W'(b / WORD_W) == wd);
            sel[b]    = s;
            spread[b] = data_in[b % WORD_W];
            if (s) word_out[b % WORD_W] = op_in[b];
        end
        last = (wd == WD_W'(N_WORDS - 1));
    end

endmodule

// File: rtl/bec_seq_ctrl.sv
// Sequencer: word-serial operand load, core start/timeout, result unload
// and a firmware-visible status word.
module bec_seq_ctrl
    import bec_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int KEY_W   = DEF_KEY_W,
    parameter int N_WORDS = n_words(KEY_W, WORD_W),
    parameter int NUM_OPS = 3,
    parameter int RES_OPS = 2,
    parameter int TIMEOUT = 20'hFFFFF
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     abort_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [WORD_W-1:0]        in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [WORD_W-1:0]        out_data_o,
    output logic                     core_start_o,
    input  logic                     core_done_i,
    output logic [NUM_OPS*KEY_W-1:0] core_ops_o,
    input  logic [RES_OPS*KEY_W-1:0] core_res_i,
    output logic [15:0]              status_o,
    output logic                     busy_o
);

    localparam int WD_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int OP_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t state, nxt;

    logic [WD_W-1:0]  wd_cnt;
    logic [OP_W-1:0]  op_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [KEY_W-1:0] ops_q [NUM_OPS];
    logic [KEY_W-1:0] res_q [RES_OPS];
    logic [KEY_W-1:0] res_sel, sel, spread;
    logic [15:0]      status_d;
    logic             busy_d;
    logic             take_in, take_out;
    logic             wd_last, op_last, res_last, to_hit;

    assign take_in  = in_valid_i & in_ready_o;
    assign take_out = out_valid_o & out_ready_i;
    assign op_last  = (op_cnt == OP_W'(NUM_OPS - 1));
    assign res_last = (op_cnt == OP_W'(RES_OPS - 1));
    assign to_hit   = (to_cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        res_sel = '0;
        for (int i = 0; i < RES_OPS; i++)
            if (op_cnt == OP_W'(i)) res_sel = res_q[i];
    end

    bec_word_packer #(
        .WORD_W (WORD_W),
        .KEY_W  (KEY_W),
        .N_WORDS(N_WORDS),
        .WD_W   (WD_W)
    ) u_packer (
        .wd      (wd_cnt),
        .data_in (in_data_i),
        .op_in   (res_sel),
        .sel     (sel),
        .spread  (spread),
        .word_out(out_data_o),
        .last    (wd_last)
    );

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_ops
        assign core_ops_o[g*KEY_W +: KEY_W] = ops_q[g];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= S_IDLE;
            status_o <= ST_IDLE;
            busy_o   <= 1'b0;
        end else begin
            state    <= nxt;
            status_o <= status_d;
            busy_o   <= busy_d;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR:
                if (in_valid_i) nxt = S_LOAD;
            S_LOAD:
                if (in_valid_i && wd_last && op_last) nxt = S_START;
            S_START:
                nxt = S_BUSY;
            S_BUSY:
                if (core_done_i) nxt = S_UNLOAD;
                else if (to_hit) nxt = S_ERR;
            S_UNLOAD:
                if (out_ready_i && wd_last && res_last) nxt = S_DONE;
            default:
                nxt = S_IDLE;
        endcase
        if (abort_i) nxt = S_IDLE;
    end

    always_comb begin
        in_ready_o   = 1'b0;
        out_valid_o  = 1'b0;
        core_start_o = 1'b0;
        unique case (state)
            S_IDLE, S_LOAD, S_DONE, S_ERR: in_ready_o   = 1'b1;
            S_START:                       core_start_o = 1'b1;
            S_UNLOAD:                      out_valid_o  = 1'b1;
            default: ;
        endcase
        busy_d   = !(nxt inside {S_IDLE, S_DONE, S_ERR});
        status_d = status_o;
        if (abort_i)                              status_d = ST_IDLE;
        else if (state != S_LOAD && nxt == S_LOAD) status_d = ST_STARTED;
        else if (state == S_START)                status_d = ST_RUN;
        else if (nxt == S_ERR)                    status_d = ST_ERR;
        else if (nxt == S_DONE)                   status_d = ST_PASS;
    end

    // Abort clears sequencing state only; operand/result registers persist.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wd_cnt <= '0;
            op_cnt <= '0;
            to_cnt <= '0;
            for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= '0;
            for (int i = 0; i < RES_OPS; i++) res_q[i] <= '0;
        end else if (abort_i) begin
            wd_cnt <= '0;
            op_cnt <= '0;
            to_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_LOAD, S_DONE, S_ERR:
                    if (take_in) begin
                        for (int i = 0; i < NUM_OPS; i++)
                            if (op_cnt == OP_W'(i))
                                ops_q[i] <= (ops_q[i] & ~sel) | (spread & sel);
                        if (wd_last) begin
                            wd_cnt <= '0;
                            op_cnt <= op_last ? '0 : op_cnt + 1'b1;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                S_START: begin
                    wd_cnt <= '0;
                    op_cnt <= '0;
                    to_cnt <= '0;
                end
                S_BUSY: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (core_done_i)
                        for (int i = 0; i < RES_OPS; i++)
                            res_q[i] <= core_res_i[i*KEY_W +: KEY_W];
                end
                S_UNLOAD:
                    if (take_out) begin
                        if (wd_last) begin
                            wd_cnt <= '0;
                            op_cnt <= res_last ? '0 : op_cnt + 1'b1;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bec_seq_ctrl.sv
// Directed/randomized bench for bec_seq_ctrl with a behavioural core model.
module tb_bec_seq_ctrl;

    logic         wb_clk_i, wb_rst_i, abort_i;
    logic         in_valid_i, in_ready_o;
    logic [31:0]  in_data_i;
    logic         out_valid_o, out_ready_i;
    logic [31:0]  out_data_o;
    logic         core_start_o, core_done_i;
    logic [488:0] core_ops_o;
    logic [325:0] core_res_i;
    logic [15:0]  status_o;
    logic         busy_o;

    int checks, errors;
    int core_delay, pending, start_cnt;
    bit spurious;
    logic [31:0]  words [18];
    logic [162:0] res_model [2];

    bec_seq_ctrl #(.TIMEOUT(1000)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .abort_i     (abort_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .core_start_o(core_start_o),
        .core_done_i (core_done_i),
        .core_ops_o  (core_ops_o),
        .core_res_i  (core_res_i),
        .status_o    (status_o),
        .busy_o      (busy_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Core model: done pulse core_delay cycles after a start (0 = never).
    initial begin
        core_done_i = 1'b0;
        pending = 0;
        start_cnt = 0;
        forever begin
            @(posedge wb_clk_i);
            #1;
            core_done_i = 1'b0;
            if (spurious) begin
                core_done_i = 1'b1;
                spurious = 1'b0;
            end
            if (pending > 0) begin
                pending--;
                if (pending == 0) core_done_i = 1'b1;
            end
            if (core_start_o) begin
                start_cnt++;
                if (core_delay > 0) pending = core_delay;
            end
        end
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [191:0] obs,
                       input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [162:0] model_op(input int j);
        logic [191:0] acc;
        for (int w = 0; w < 6; w++) acc[32*w +: 32] = words[6*j + w];
        return acc[162:0];
    endfunction

    function automatic logic [31:0] exp_word(input int r, input int w);
        logic [191:0] p;
        p = {29'b0, res_model[r]};
        return p[32*w +: 32];
    endfunction

    task automatic rand_words();
        for (int i = 0; i < 18; i++) words[i] = $urandom;
    endtask

    task automatic new_res();
        logic [191:0] t;
        for (int r = 0; r < 2; r++) begin
            t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            res_model[r] = t[162:0];
        end
        core_res_i = {res_model[1], res_model[0]};
    endtask

    task automatic load_all();
        for (int i = 0; i < 18; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = words[i];
            chk("in_ready", in_ready_o, 1);
            tick();
            if (i == 0) chk("status_started", status_o, 16'hAB40);
        end
        in_valid_i = 1'b0;
        chk("start_pulse", core_start_o, 1);
        for (int j = 0; j < 3; j++)
            chk("core_op", core_ops_o[j*163 +: 163], model_op(j));
    endtask

    task automatic unload_all(input int stall_at);
        int c;
        bit bad;
        c = 0;
        bad = 1'b0;
        while (!out_valid_o && c < 2000) begin
            tick();
            c++;
        end
        chk("out_valid_wait", out_valid_o, 1);
        for (int i = 0; i < 12; i++) begin
            chk("out_data", out_data_o, exp_word(i / 6, i % 6));
            if (i % 6 == 5) chk("res_w5_upper", out_data_o[31:3], 0);
            if (i == stall_at) begin
                out_ready_i = 1'b0;
                repeat (10) begin
                    tick();
                    if (!out_valid_o || out_data_o !== exp_word(i / 6, i % 6))
                        bad = 1'b1;
                end
                chk("stall_stable", bad, 0);
            end
            out_ready_i = 1'b1;
            tick();
            out_ready_i = 1'b0;
        end
        chk("out_valid_done", out_valid_o, 0);
        chk("status_pass", status_o, 16'hAB51);
        chk("busy_done", busy_o, 0);
    endtask

    initial begin
        int n;
        bit bad;
        checks = 0;
        errors = 0;
        wb_rst_i = 1'b1;
        abort_i = 1'b0;
        in_valid_i = 1'b0;
        in_data_i = '0;
        out_ready_i = 1'b0;
        core_res_i = '0;
        core_delay = 100;
        spurious = 1'b0;

        #12;
        chk("rst_status", status_o, 16'hAB00);
        chk("rst_busy", busy_o, 0);
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_start", core_start_o, 0);
        chk("rst_ops", core_ops_o[162:0], 0);
        tick();
        wb_rst_i = 1'b0;
        tick();

        // Run A: counting words
        for (int i = 0; i < 18; i++) words[i] = 32'(i + 1);
        new_res();
        load_all();
        tick();
        chk("pulse_one_cycle", core_start_o, 0);
        chk("status_run", status_o, 16'hAB41);
        chk("busy_run", busy_o, 1);
        unload_all(-1);

        // Run B: all-ones final words, stalled unload
        rand_words();
        words[5] = 32'hFFFF_FFFF;
        words[11] = 32'hFFFF_FFFF;
        words[17] = 32'hFFFF_FFFF;
        new_res();
        load_all();
        for (int j = 0; j < 3; j++)
            chk("op_top_bits", core_ops_o[j*163 + 160 +: 3], 3'b111);
        tick();
        chk("status_run_b", status_o, 16'hAB41);
        unload_all(3);

        // Timeout
        core_delay = 0;
        rand_words();
        load_all();
        n = 0;
        while (busy_o && n < 3000) begin
            tick();
            n++;
        end
        chk("timeout_cycles", n, 1001);
        chk("status_err", status_o, 16'hABEE);
        chk("err_busy", busy_o, 0);
        chk("err_in_ready", in_ready_o, 1);
        chk("err_out_valid", out_valid_o, 0);

        // Abort during word 7, then a fresh load
        core_delay = 100;
        rand_words();
        for (int i = 0; i < 7; i++) begin
            in_valid_i = 1'b1;
            in_data_i = words[i];
            tick();
        end
        in_data_i = words[7];
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        in_valid_i = 1'b0;
        chk("abort_status", status_o, 16'hAB00);
        chk("abort_busy", busy_o, 0);
        chk("abort_in_ready", in_ready_o, 1);
        chk("abort_out_valid", out_valid_o, 0);
        tick();
        rand_words();
        new_res();
        load_all();
        tick();
        chk("status_run_c", status_o, 16'hAB41);
        unload_all(-1);

        // Reset while busy, then stray done pulses
        core_delay = 40;
        rand_words();
        load_all();
        repeat (3) tick();
        #2;
        wb_rst_i = 1'b1;
        #1;
        chk("mid_rst_status", status_o, 16'hAB00);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_start", core_start_o, 0);
        chk("mid_rst_out_valid", out_valid_o, 0);
        for (int j = 0; j < 3; j++)
            chk("mid_rst_ops", core_ops_o[j*163 +: 163], 0);
        tick();
        wb_rst_i = 1'b0;
        spurious = 1'b1;
        bad = 1'b0;
        repeat (80) begin
            tick();
            if (out_valid_o || busy_o || status_o !== 16'hAB00) bad = 1'b1;
        end
        chk("no_unload_after_rst", bad, 0);
        chk("start_pulses", start_cnt, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
